register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file_read_port.sv | 50 +++++
 rtl/register_file.sv | 102 ++++++++++
 tb/tb_register_file.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared register-file constants and types. The reorder buffer and the
// instruction unit import this package too, so the sizes stay consistent.
package register_file_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ROB_WIDTH      = 4;
    localparam int DATA_WIDTH     = 32;

    // Architectural zero register: hardwired to zero and never renamed
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = 5'd0;

    typedef logic [DATA_WIDTH-1:0]     regWord_t;
    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One query port: stored lookup plus same-cycle commit bypass.
// x0 always reads as an idle zero register.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0]                queryReg,
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]     storedValue,
    input  logic [REG_COUNT-1:0]                     storedBusy,
    input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0]      storedDep,
    input  logic                                     regUpdateValid,
    input  logic [REG_ADDR_WIDTH-1:0]                regUpdateDest,
    input  logic [DATA_WIDTH-1:0]                    regValue,
    input  logic [ROB_WIDTH-1:0]                     regUpdateRobId,
    output logic                                     queryBusy,
    output logic [DATA_WIDTH-1:0]                    queryValue,
    output logic [ROB_WIDTH-1:0]                     queryDep
);

    logic bypassHitS;

    // A commit bypasses only when it is the producer the register waits on
    always_comb begin
        bypassHitS = regUpdateValid
                     && (regUpdateDest == queryReg)
                     && (regUpdateDest != REG_X0)
                     && storedBusy[queryReg]
                     && (storedDep[queryReg] == regUpdateRobId);
    end

    // Select between x0 constant, bypassed commit data and stored state
    always_comb begin
        queryBusy  = storedBusy[queryReg];
        queryValue = storedValue[queryReg];
        queryDep   = storedDep[queryReg];
        if (queryReg == REG_X0) begin
            queryBusy  = 1'b0;
            queryValue = {DATA_WIDTH{1'b0}};
            queryDep   = {ROB_WIDTH{1'b0}};
        end else if (bypassHitS) begin
            queryBusy  = 1'b0;
            queryValue = regValue;
        end else begin
            queryBusy  = storedBusy[queryReg];
            queryValue = storedValue[queryReg];
        end
    end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// Architectural register file with rename (busy/dep) tracking, commit
// writeback, mispredict flush and two combinational query ports.
// Built from flops so both ports can bypass the committing value.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      clear,
    input  logic                      regUpdateValid,
    input  logic [REG_ADDR_WIDTH-1:0] regUpdateDest,
    input  logic [DATA_WIDTH-1:0]     regValue,
    input  logic [ROB_WIDTH-1:0]      regUpdateRobId,
    input  logic                      setDepValid,
    input  logic [REG_ADDR_WIDTH-1:0] setDepReg,
    input  logic [ROB_WIDTH-1:0]      setDepRobId,
    input  logic [REG_ADDR_WIDTH-1:0] rs1Reg,
    input  logic [REG_ADDR_WIDTH-1:0] rs2Reg,
    output logic                      rs1Busy,
    output logic [DATA_WIDTH-1:0]     rs1Value,
    output logic [ROB_WIDTH-1:0]      rs1Dep,
    output logic                      rs2Busy,
    output logic [DATA_WIDTH-1:0]     rs2Value,
    output logic [ROB_WIDTH-1:0]      rs2Dep
);

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] valueR;
    logic [REG_COUNT-1:0]                 busyR;
    logic [REG_COUNT-1:0][ROB_WIDTH-1:0]  depR;

    logic [REG_COUNT-1:0] commitWriteS;
    logic [REG_COUNT-1:0] commitClearS;
    logic [REG_COUNT-1:0] setDepHitS;

    // Per-register decode of commit writes, producer matches and renames
    always_comb begin
        commitWriteS = {REG_COUNT{1'b0}};
        commitClearS = {REG_COUNT{1'b0}};
        setDepHitS   = {REG_COUNT{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            commitWriteS[i] = regUpdateValid && (regUpdateDest == REG_ADDR_WIDTH'(i));
            commitClearS[i] = commitWriteS[i] && busyR[i] && (depR[i] == regUpdateRobId);
            setDepHitS[i]   = setDepValid && !clear && (setDepReg == REG_ADDR_WIDTH'(i));
        end
    end

    // Register state update: reset, then values, then busy/dep priority
    // (flush > rename > matching commit)
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            valueR <= {(REG_COUNT*DATA_WIDTH){1'b0}};
            busyR  <= {REG_COUNT{1'b0}};
            depR   <= {(REG_COUNT*ROB_WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (commitWriteS[i]) begin
                    valueR[i] <= regValue;
                end
                if (clear) begin
                    busyR[i] <= 1'b0;
                    depR[i]  <= {ROB_WIDTH{1'b0}};
                end else if (setDepHitS[i]) begin
                    busyR[i] <= 1'b1;
                    depR[i]  <= setDepRobId;
                end else if (commitClearS[i]) begin
                    busyR[i] <= 1'b0;
                end
            end
        end
    end

    register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) rs1Port (
        .queryReg       (rs1Reg),
        .storedValue    (valueR),
        .storedBusy     (busyR),
        .storedDep      (depR),
        .regUpdateValid (regUpdateValid),
        .regUpdateDest  (regUpdateDest),
        .regValue       (regValue),
        .regUpdateRobId (regUpdateRobId),
        .queryBusy      (rs1Busy),
        .queryValue     (rs1Value),
        .queryDep       (rs1Dep)
    );

    register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) rs2Port (
        .queryReg       (rs2Reg),
        .storedValue    (valueR),
        .storedBusy     (busyR),
        .storedDep      (depR),
        .regUpdateValid (regUpdateValid),
        .regUpdateDest  (regUpdateDest),
        .regValue       (regValue),
        .regUpdateRobId (regUpdateRobId),
        .queryBusy      (rs2Busy),
        .queryValue     (rs2Value),
        .queryDep       (rs2Dep)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file with hand-computed expectations.
module tb_register_file;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        clear;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regValue;
    logic [3:0]  regUpdateRobId;
    logic        setDepValid;
    logic [4:0]  setDepReg;
    logic [3:0]  setDepRobId;
    logic [4:0]  rs1Reg;
    logic [4:0]  rs2Reg;
    logic        rs1Busy;
    logic [31:0] rs1Value;
    logic [3:0]  rs1Dep;
    logic        rs2Busy;
    logic [31:0] rs2Value;
    logic [3:0]  rs2Dep;

    int compared   = 0;
    int mismatched = 0;

    register_file dut (
        .clockIn        (clockIn),
        .resetIn        (resetIn),
        .clear          (clear),
        .regUpdateValid (regUpdateValid),
        .regUpdateDest  (regUpdateDest),
        .regValue       (regValue),
        .regUpdateRobId (regUpdateRobId),
        .setDepValid    (setDepValid),
        .setDepReg      (setDepReg),
        .setDepRobId    (setDepRobId),
        .rs1Reg         (rs1Reg),
        .rs2Reg         (rs2Reg),
        .rs1Busy        (rs1Busy),
        .rs1Value       (rs1Value),
        .rs1Dep         (rs1Dep),
        .rs2Busy        (rs2Busy),
        .rs2Value       (rs2Value),
        .rs2Dep         (rs2Dep)
    );

    always #5 clockIn = ~clockIn;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it
    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    // Query rs1 and check busy/value/dep after combinational settling
    task automatic checkRs1(input string tag, input logic [4:0] r, input logic b,
                            input logic [31:0] v, input logic [3:0] d);
        rs1Reg = r;
        #1;
        checkVal({tag, ".busy"},  {31'd0, rs1Busy}, {31'd0, b});
        checkVal({tag, ".value"}, rs1Value, v);
        checkVal({tag, ".dep"},   {28'd0, rs1Dep}, {28'd0, d});
    endtask

    initial begin
        resetIn = 1'b0; clear = 1'b0;
        regUpdateValid = 1'b0; regUpdateDest = 5'd0; regValue = 32'd0; regUpdateRobId = 4'd0;
        setDepValid = 1'b0; setDepReg = 5'd0; setDepRobId = 4'd0;
        rs1Reg = 5'd0; rs2Reg = 5'd0;

        // Reset state
        tick(); tick();
        checkRs1("reset_x5", 5'd5, 1'b0, 32'h0, 4'd0);
        resetIn = 1'b1;

        // Rename x5 -> rob3, then matching commit with bypass
        setDepValid = 1'b1; setDepReg = 5'd5; setDepRobId = 4'd3;
        tick();
        setDepValid = 1'b0;
        checkRs1("dep_x5", 5'd5, 1'b1, 32'h0, 4'd3);
        regUpdateValid = 1'b1; regUpdateDest = 5'd5; regValue = 32'h1234; regUpdateRobId = 4'd3;
        #1;
        checkVal("bypass_x5.busy",  {31'd0, rs1Busy}, 32'd0);
        checkVal("bypass_x5.value", rs1Value, 32'h1234);
        tick();
        regUpdateValid = 1'b0;
        checkRs1("commit_x5", 5'd5, 1'b0, 32'h1234, 4'd3);

        // Two renames, stale commit writes value but keeps newer producer
        setDepValid = 1'b1; setDepReg = 5'd5; setDepRobId = 4'd3;
        tick();
        setDepRobId = 4'd7;
        tick();
        setDepValid = 1'b0;
        regUpdateValid = 1'b1; regUpdateDest = 5'd5; regValue = 32'hAA; regUpdateRobId = 4'd3;
        checkRs1("stale_nobypass", 5'd5, 1'b1, 32'h1234, 4'd7);
        tick();
        regUpdateValid = 1'b0;
        checkRs1("stale_commit", 5'd5, 1'b1, 32'hAA, 4'd7);
        regUpdateValid = 1'b1; regValue = 32'hBB; regUpdateRobId = 4'd7;
        tick();
        regUpdateValid = 1'b0;
        checkRs1("rob7_commit", 5'd5, 1'b0, 32'hBB, 4'd7);

        // Same-cycle commit and rename on x6: rename wins busy/dep
        regUpdateValid = 1'b1; regUpdateDest = 5'd6; regValue = 32'h66; regUpdateRobId = 4'd2;
        setDepValid = 1'b1; setDepReg = 5'd6; setDepRobId = 4'd9;
        #1;
        checkVal("nosee_setdep.busy", {31'd0, rs1Busy}, 32'd0);
        tick();
        regUpdateValid = 1'b0; setDepValid = 1'b0;
        checkRs1("x6_both", 5'd6, 1'b1, 32'h66, 4'd9);
        rs2Reg = 5'd6;
        #1;
        checkVal("rs2_same.busy",  {31'd0, rs2Busy}, 32'd1);
        checkVal("rs2_same.value", rs2Value, 32'h66);
        checkVal("rs2_same.dep",   {28'd0, rs2Dep}, 32'd9);

        // Busy x1..x4, then flush with a rename and a commit in the same cycle
        for (int i = 1; i <= 4; i++) begin
            setDepValid = 1'b1; setDepReg = 5'(i); setDepRobId = 4'(i);
            tick();
        end
        setDepValid = 1'b0;
        checkRs1("pre_clear_x4", 5'd4, 1'b1, 32'h0, 4'd4);
        clear = 1'b1;
        setDepValid = 1'b1; setDepReg = 5'd7; setDepRobId = 4'd1;
        regUpdateValid = 1'b1; regUpdateDest = 5'd3; regValue = 32'h333; regUpdateRobId = 4'd9;
        tick();
        clear = 1'b0; setDepValid = 1'b0; regUpdateValid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            checkRs1("clear_x1x2", 5'(i), 1'b0, 32'h0, 4'd0);
        end
        checkRs1("clear_x3", 5'd3, 1'b0, 32'h333, 4'd0);
        checkRs1("clear_x4", 5'd4, 1'b0, 32'h0, 4'd0);
        checkRs1("clear_x7", 5'd7, 1'b0, 32'h0, 4'd0);
        checkRs1("clear_x6", 5'd6, 1'b0, 32'h66, 4'd0);
        checkRs1("clear_x5", 5'd5, 1'b0, 32'hBB, 4'd0);

        // x0 ignores rename and commit
        setDepValid = 1'b1; setDepReg = 5'd0; setDepRobId = 4'd5;
        regUpdateValid = 1'b1; regUpdateDest = 5'd0; regValue = 32'hFFFFFFFF; regUpdateRobId = 4'd5;
        checkRs1("x0_during", 5'd0, 1'b0, 32'h0, 4'd0);
        tick();
        setDepValid = 1'b0; regUpdateValid = 1'b0;
        checkRs1("x0_after", 5'd0, 1'b0, 32'h0, 4'd0);

        // Pending dependency discarded by reset, values cleared
        setDepValid = 1'b1; setDepReg = 5'd8; setDepRobId = 4'd2;
        tick();
        setDepValid = 1'b0;
        checkRs1("x8_pending", 5'd8, 1'b1, 32'h0, 4'd2);
        resetIn = 1'b0;
        setDepValid = 1'b1; setDepReg = 5'd9; setDepRobId = 4'd4;
        regUpdateValid = 1'b1; regUpdateDest = 5'd6; regValue = 32'h77; regUpdateRobId = 4'd1;
        tick();
        setDepValid = 1'b0; regUpdateValid = 1'b0;
        checkRs1("rst_x8", 5'd8, 1'b0, 32'h0, 4'd0);
        checkRs1("rst_x9", 5'd9, 1'b0, 32'h0, 4'd0);
        checkRs1("rst_x6", 5'd6, 1'b0, 32'h0, 4'd0);
        rs2Reg = 5'd5;
        #1;
        checkVal("rst_rs2_x5.value", rs2Value, 32'h0);
        resetIn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file
